rv_hazard_ctrl: RTL and testbench
=================================

// Module: rv_hazard_ctrl
// PURPOSE
//  Parametrised hazard/stall controller for the in-order RV pipeline; supersedes the single-cycle load-use detector.
//  Detects load-use hazards against N ID-stage sources, holds multi-cycle load stalls, flushes on taken branch,
//  and freezes the whole pipe while data memory is busy. Sits beside the IF/ID and ID/EX registers.
//  Also keeps a saturating stall-cycle counter for performance debug.
// PARAMETERS
//  REG_AW        5  register-index width
//  NUM_SRC       2  number of ID-stage source operands compared (1..3)
//  LOAD_STALL    1  bubble cycles inserted per load-use hazard (1..7)
//  IGNORE_X0     1  1: a source or destination index of 0 never creates a hazard
//  CNT_W        16  width of stall_count
// PORTS
//  clk            in   1               pipeline clock
//  rst_n          in   1               asynchronous active-low reset
//  ifid_rs        in   NUM_SRC*REG_AW  ID-stage source indices; src i at [i*REG_AW +: REG_AW]
//  ifid_rs_used   in   NUM_SRC         bit i = 1 when src i is actually read by the ID instruction
//  idex_rd        in   REG_AW          destination index of the EX-stage instruction
//  idex_mem_read  in   1               EX-stage instruction is a load
//  branch_taken   in   1               EX-stage branch/jump resolved taken (redirect this cycle)
//  dmem_busy      in   1               data memory not ready; the MEM stage must hold
//  pc_write       out  1               1 = PC may update
//  ifid_write     out  1               1 = IF/ID may load
//  ifid_flush     out  1               1 = clear IF/ID to NOP at next edge
//  idex_bubble    out  1               1 = load NOP into ID/EX (hazard flag)
//  pipe_freeze    out  1               1 = hold ID/EX, EX/MEM, MEM/WB unchanged
//  stall_count    out  CNT_W           saturating count of cycles with idex_bubble or pipe_freeze set
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, stall_count=0. While rst_n=0, all control outputs are 0.
//  match = OR over i of (ifid_rs_used[i] & ifid_rs[i]==idex_rd & !(IGNORE_X0 & idex_rd==0)).
//  hazard = idex_mem_read & match. Outputs are combinational from state and inputs; state updates on posedge clk.
//  Priority per cycle: dmem_busy > branch_taken > hazard/STALL > normal.
//   dmem_busy=1: pipe_freeze=1, pc_write=0, ifid_write=0, bubble=0, flush=0. State and cnt hold.
//    A branch_taken that is asserted during the freeze is held upstream and acted on once busy drops.
//   branch_taken=1, not busy: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1. State goes to IDLE
//    and cnt=0; this aborts any stall in progress, because the ID instruction is wrong-path.
//   IDLE with hazard=1: idex_bubble=1, pc_write=0, ifid_write=0 in the same cycle (zero-latency detect).
//    If LOAD_STALL>1, go to STALL with cnt=LOAD_STALL-1. Otherwise stay in IDLE.
//   STALL: idex_bubble=1, pc_write=0, ifid_write=0. cnt decrements each unfrozen cycle.
//    When cnt==1 at the clock edge, go to IDLE. The hazard is not re-evaluated while in STALL.
//   IDLE with no hazard: pc_write=1, ifid_write=1, all other controls 0.
//  Total bubbles per load-use hazard = exactly LOAD_STALL (not counting freeze cycles).
//  stall_count: +1 per cycle with (idex_bubble | pipe_freeze); saturates at all-ones and never wraps.
//  Reset asserted mid-STALL returns to IDLE asynchronously; no residual bubble follows reset release.
//  Parameters outside their stated range are a elaboration error ($error in an initial/generate check).
// STRUCTURE
//  rv_hazard_pkg: typedef enum logic {IDLE, STALL} hz_state_t; localparam REG_AW_DEF=5; function clog2-safe cnt width.
//  Sub-module rv_hazard_match: purely combinational NUM_SRC comparator (rs vector, used mask, rd, IGNORE_X0) -> match.
//  Top: FSM + down-counter ($clog2(LOAD_STALL+1) bits) + saturating stall counter + output priority mux.
// TESTING
//  LOAD_STALL=1: load x5 in EX, ID uses rs1=x5 -> 1 cycle idex_bubble=1, pc_write=0; next cycle all normal.
//  LOAD_STALL=3: same hazard -> idex_bubble high exactly 3 consecutive cycles; stall_count goes 0->3.
//  IGNORE_X0=1: load x0, ID rs2=x0 used -> no bubble. With ifid_rs_used[1]=0 and rs2 matching -> no bubble.
//  LOAD_STALL=3: branch_taken in 2nd stall cycle -> ifid_flush=1 that cycle, state IDLE, no 3rd bubble.
//  dmem_busy high 4 cycles in mid-STALL -> pipe_freeze=1 for 4 cycles, cnt held; remaining bubbles resume after.
//  CNT_W=4: force 20 stall cycles -> stall_count holds at 15. rst_n low mid-STALL -> outputs 0, IDLE after release.

Source files
------------

// File: rtl/rv_hazard_pkg.sv
// Shared types and helpers for the RV pipeline hazard/stall controller.
package rv_hazard_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  localparam int REG_AW_DEF = 5;

  // Bubble down-counter width; never narrower than one bit.
  function automatic int stall_cnt_w(input int load_stall);
    int w;
    w = $clog2(load_stall + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rv_hazard_match.sv
// Compares every used ID-stage source index against the EX-stage destination index.
module rv_hazard_match
  import rv_hazard_pkg::*;
#(
  parameter int REG_AW    = REG_AW_DEF,
  parameter int NUM_SRC   = 2,
  parameter int IGNORE_X0 = 1
) (
  input  logic [NUM_SRC*REG_AW-1:0] rs_i,
  input  logic [NUM_SRC-1:0]        used_i,
  input  logic [REG_AW-1:0]         rd_i,
  output logic                      match_o
);

  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (used_i[i] && (rs_i[i*REG_AW +: REG_AW] == rd_i)) begin
        match_o = 1'b1;
      end
    end
    // x0 is hardwired to zero, so a write to it can never feed a dependent read.
    if ((IGNORE_X0 != 0) && (rd_i == '0)) begin
      match_o = 1'b0;
    end
  end

endmodule

// File: rtl/rv_hazard_ctrl.sv
// Load-use stall, branch flush and memory-busy freeze controller for the in-order RV pipeline.
module rv_hazard_ctrl
  import rv_hazard_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_STALL = 1,
  parameter int IGNORE_X0  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] ifid_rs,
  input  logic [NUM_SRC-1:0]        ifid_rs_used,
  input  logic [REG_AW-1:0]         idex_rd,
  input  logic                      idex_mem_read,
  input  logic                      branch_taken,
  input  logic                      dmem_busy,
  output logic                      pc_write,
  output logic                      ifid_write,
  output logic                      ifid_flush,
  output logic                      idex_bubble,
  output logic                      pipe_freeze,
  output logic [CNT_W-1:0]          stall_count
);

  localparam int CW = stall_cnt_w(LOAD_STALL);

  if ((NUM_SRC < 1) || (NUM_SRC > 3) || (LOAD_STALL < 1) || (LOAD_STALL > 7) ||
      (REG_AW < 1) || (CNT_W < 1) || (IGNORE_X0 < 0) || (IGNORE_X0 > 1)) begin : g_bad_param
    $error("rv_hazard_ctrl: parameter out of range");
  end

  hz_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             match, hazard;
  logic             pc_d, ifw_d, flush_d, bubble_d, freeze_d;

  rv_hazard_match #(
    .REG_AW   (REG_AW),
    .NUM_SRC  (NUM_SRC),
    .IGNORE_X0(IGNORE_X0)
  ) u_match (
    .rs_i   (ifid_rs),
    .used_i (ifid_rs_used),
    .rd_i   (idex_rd),
    .match_o(match)
  );

  assign hazard = idex_mem_read & match;

  always_comb begin
    pc_d     = 1'b1;
    ifw_d    = 1'b1;
    flush_d  = 1'b0;
    bubble_d = 1'b0;
    freeze_d = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    if (dmem_busy) begin
      freeze_d = 1'b1;
      pc_d     = 1'b0;
      ifw_d    = 1'b0;
    end else if (branch_taken) begin
      // ID holds a wrong-path instruction, so any stall in progress is moot.
      flush_d  = 1'b1;
      bubble_d = 1'b1;
      state_d  = IDLE;
      cnt_d    = '0;
    end else if (state_q == STALL) begin
      bubble_d = 1'b1;
      pc_d     = 1'b0;
      ifw_d    = 1'b0;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
      end
    end else if (hazard) begin
      bubble_d = 1'b1;
      pc_d     = 1'b0;
      ifw_d    = 1'b0;
      if (LOAD_STALL > 1) begin
        state_d = STALL;
        cnt_d   = CW'(LOAD_STALL - 1);
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if ((bubble_d || freeze_d) && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pc_write    = rst_n & pc_d;
  assign ifid_write  = rst_n & ifw_d;
  assign ifid_flush  = rst_n & flush_d;
  assign idex_bubble = rst_n & bubble_d;
  assign pipe_freeze = rst_n & freeze_d;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Bench for rv_hazard_ctrl: LOAD_STALL=3 and LOAD_STALL=1/CNT_W=4 instances against a pending-bubble model.
module tb_rv_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] rs;
  logic [1:0] used;
  logic [4:0] rd;
  logic       mr, br, busy;

  logic pc3, iw3, fl3, bb3, fz3;
  logic pc1, iw1, fl1, bb1, fz1;
  logic [15:0] sc3_o;
  logic [3:0]  sc1_o;
  logic [4:0]  o3, o1;
  assign o3 = {pc3, iw3, fl3, bb3, fz3};
  assign o1 = {pc1, iw1, fl1, bb1, fz1};

  int vectors = 0;
  int miscompares = 0;
  int p3 = 0, p1 = 0, sc3 = 0, sc1 = 0;

  localparam logic [4:0] O_NORM   = 5'b11000;
  localparam logic [4:0] O_BUBBLE = 5'b00010;
  localparam logic [4:0] O_FLUSH  = 5'b11110;
  localparam logic [4:0] O_FREEZE = 5'b00001;

  rv_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_STALL(3), .IGNORE_X0(1), .CNT_W(16)) u_ls3 (
    .clk(clk), .rst_n(rst_n), .ifid_rs(rs), .ifid_rs_used(used), .idex_rd(rd),
    .idex_mem_read(mr), .branch_taken(br), .dmem_busy(busy),
    .pc_write(pc3), .ifid_write(iw3), .ifid_flush(fl3), .idex_bubble(bb3),
    .pipe_freeze(fz3), .stall_count(sc3_o));

  rv_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_STALL(1), .IGNORE_X0(1), .CNT_W(4)) u_ls1 (
    .clk(clk), .rst_n(rst_n), .ifid_rs(rs), .ifid_rs_used(used), .idex_rd(rd),
    .idex_mem_read(mr), .branch_taken(br), .dmem_busy(busy),
    .pc_write(pc1), .ifid_write(iw1), .ifid_flush(fl1), .idex_bubble(bb1),
    .pipe_freeze(fz1), .stall_count(sc1_o));

  function automatic bit hz();
    bit m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (used[i] && (rs[i*5 +: 5] == rd) && (rd != 5'd0)) m = 1'b1;
    end
    return mr && m;
  endfunction

  // p = bubbles still owed from an earlier load-use hazard.
  function automatic logic [4:0] exp_out(input int p);
    if (!rst_n) return 5'b00000;
    if (busy)   return O_FREEZE;
    if (br)     return O_FLUSH;
    if (p > 0 || hz()) return O_BUBBLE;
    return O_NORM;
  endfunction

  task automatic tick();
    logic [4:0] e3, e1;
    bit h;
    e3 = exp_out(p3);
    e1 = exp_out(p1);
    h  = hz();
    @(posedge clk);
    if (rst_n) begin
      if (e3[1] || e3[0]) sc3 = (sc3 >= 65535) ? 65535 : sc3 + 1;
      if (e1[1] || e1[0]) sc1 = (sc1 >= 15) ? 15 : sc1 + 1;
      if (!busy) begin
        if (br) begin
          p3 = 0; p1 = 0;
        end else begin
          if (p3 > 0) p3 = p3 - 1; else if (h) p3 = 2;
          if (p1 > 0) p1 = p1 - 1; else if (h) p1 = 0;
        end
      end
    end
    #1;
  endtask

  task automatic set_in(input logic [4:0] r1, input logic [4:0] r2, input logic [1:0] u,
                        input logic [4:0] d, input logic m, input logic b, input logic bz);
    rs = {r2, r1}; used = u; rd = d; mr = m; br = b; busy = bz;
    #2;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(5'($urandom), 5'($urandom), 2'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      vectors++;
      if (o3 !== 5'b0 || o1 !== 5'b0 || sc3_o !== 16'd0 || sc1_o !== 4'd0) begin
        miscompares++;
        $display("FAIL reset k=%0d: got o3=%b o1=%b sc3=%0d sc1=%0d, want all zero", k, o3, o1, sc3_o, sc1_o);
      end
      @(posedge clk); #1;
    end
    set_in(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    p3 = 0; p1 = 0; sc3 = 0; sc1 = 0;
    #1;
    vectors++;
    if (o3 !== O_NORM || o1 !== O_NORM) begin
      miscompares++;
      $display("FAIL reset_release: got o3=%b o1=%b want %b", o3, o1, O_NORM);
    end
    tick();
  endtask

  task automatic test_load_use();
    set_in(5'd5, 5'd9, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) set_in(5'd5, 5'd9, 2'b11, 5'd5, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (bb3 !== (k < 3) || pc3 !== (k >= 3) || bb1 !== (k < 1) || pc1 !== (k >= 1) ||
          o3 !== exp_out(p3) || o1 !== exp_out(p1)) begin
        miscompares++;
        $display("FAIL load_use k=%0d: got o3=%b o1=%b want o3=%b o1=%b", k, o3, o1, exp_out(p3), exp_out(p1));
      end
      tick();
    end
    vectors++;
    if (sc3_o !== 16'd3 || sc1_o !== 4'd1) begin
      miscompares++;
      $display("FAIL load_use_count: got sc3=%0d sc1=%0d want 3 1", sc3_o, sc1_o);
    end
  endtask

  task automatic test_x0();
    set_in(5'd3, 5'd0, 2'b11, 5'd0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (o3 !== O_NORM || o1 !== O_NORM) begin
      miscompares++;
      $display("FAIL x0_dest: got o3=%b o1=%b want %b", o3, o1, O_NORM);
    end
    tick();
    set_in(5'd3, 5'd7, 2'b01, 5'd7, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (o3 !== O_NORM || o1 !== O_NORM) begin
      miscompares++;
      $display("FAIL unused_src: got o3=%b o1=%b want %b", o3, o1, O_NORM);
    end
    tick();
    set_in(5'd3, 5'd7, 2'b10, 5'd7, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) set_in(5'd3, 5'd7, 2'b10, 5'd7, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (bb3 !== (k < 3) || o3 !== exp_out(p3) || o1 !== exp_out(p1)) begin
        miscompares++;
        $display("FAIL src2_hazard k=%0d: got o3=%b o1=%b want o3=%b o1=%b", k, o3, o1, exp_out(p3), exp_out(p1));
      end
      tick();
    end
  endtask

  task automatic test_branch_abort();
    set_in(5'd5, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (o3 !== O_BUBBLE) begin
      miscompares++;
      $display("FAIL branch_pre: got o3=%b want %b", o3, O_BUBBLE);
    end
    tick();
    set_in(5'd5, 5'd0, 2'b01, 5'd5, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (o3 !== O_FLUSH || o1 !== O_FLUSH) begin
      miscompares++;
      $display("FAIL branch_flush: got o3=%b o1=%b want %b", o3, o1, O_FLUSH);
    end
    tick();
    set_in(5'd5, 5'd0, 2'b01, 5'd5, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (o3 !== O_NORM || o1 !== O_NORM) begin
      miscompares++;
      $display("FAIL branch_after: got o3=%b o1=%b want %b", o3, o1, O_NORM);
    end
    tick();
  endtask

  task automatic test_freeze();
    int sc_start;
    sc_start = sc3;
    set_in(5'd6, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(5'd6, 5'd0, 2'b01, 5'd6, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (o3 !== O_FREEZE || o1 !== O_FREEZE) begin
        miscompares++;
        $display("FAIL freeze k=%0d: got o3=%b o1=%b want %b", k, o3, o1, O_FREEZE);
      end
      tick();
    end
    // The branch seen during the freeze is held upstream; it is dropped here so the stall resumes.
    set_in(5'd6, 5'd0, 2'b01, 5'd6, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (bb3 !== (k < 2) || o3 !== exp_out(p3) || o1 !== O_NORM) begin
        miscompares++;
        $display("FAIL freeze_resume k=%0d: got o3=%b o1=%b want o3=%b o1=%b", k, o3, o1, exp_out(p3), O_NORM);
      end
      tick();
    end
    vectors++;
    if (sc3_o !== 16'(sc_start + 7)) begin
      miscompares++;
      $display("FAIL freeze_count: got %0d want %0d", sc3_o, sc_start + 7);
    end
  endtask

  task automatic test_reset_mid_stall();
    set_in(5'd4, 5'd0, 2'b01, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(5'd4, 5'd0, 2'b01, 5'd4, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    p3 = 0; p1 = 0; sc3 = 0; sc1 = 0;
    #1;
    vectors++;
    if (o3 !== 5'b0 || o1 !== 5'b0 || sc3_o !== 16'd0 || sc1_o !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got o3=%b o1=%b sc3=%0d sc1=%0d want zeros", o3, o1, sc3_o, sc1_o);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (o3 !== O_NORM || o1 !== O_NORM) begin
        miscompares++;
        $display("FAIL reset_release_stall k=%0d: got o3=%b o1=%b want %b", k, o3, o1, O_NORM);
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    set_in(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) tick();
    vectors++;
    if (sc1_o !== 4'hF || sc1 != 15 || sc3_o !== 16'(sc3)) begin
      miscompares++;
      $display("FAIL saturate: got sc1=%0d sc3=%0d want sc1=15 sc3=%0d", sc1_o, sc3_o, sc3);
    end
    set_in(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
      vectors++;
      if (o3 !== exp_out(p3) || o1 !== exp_out(p1) || sc3_o !== 16'(sc3) || sc1_o !== 4'(sc1)) begin
        miscompares++;
        $display("FAIL random k=%0d: got o3=%b o1=%b sc3=%0d sc1=%0d want o3=%b o1=%b sc3=%0d sc1=%0d",
                 k, o3, o1, sc3_o, sc1_o, exp_out(p3), exp_out(p1), sc3, sc1);
      end
      tick();
    end
  endtask

  initial begin
    rs = '0; used = '0; rd = '0; mr = 1'b0; br = 1'b0; busy = 1'b0;
    test_reset();
    test_load_use();
    test_x0();
    test_branch_abort();
    test_freeze();
    test_reset_mid_stall();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
